// File: rtl/sw_debounce.sv
// Switch/button conditioning: per-input synchronizer plus stability-counter
// debounce, with registered press/release/change strobes for the core.

module sw_debounce_chan #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic raw_i,
  output logic stable_o,
  output logic accept_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   synced;
  logic                   accept;

  assign synced = sync_q[SYNC_STAGES-1];

  // Any cycle where synced agrees with stable restarts the window, so only
  // an unbroken run of DEBOUNCE_CYCLES disagreeing samples is accepted.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
    stable_d = stable_q;
    cnt_d    = '0;
    accept   = 1'b0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        accept   = 1'b1;
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign accept_o = accept;
endmodule

module sw_debounce #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] sw_raw_i,
  input  logic             key_raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic             key_pressed_o,
  output logic             key_press_o,
  output logic             key_release_o,
  output logic             sw_changed_o
);
  logic [WIDTH-1:0] sw_stable, sw_accept;
  logic             key_stable, key_accept;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             changed_q, changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sw
    sw_debounce_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .raw_i    (sw_raw_i[i]),
      .stable_o (sw_stable[i]),
      .accept_o (sw_accept[i])
    );
  end

  // Button idles high; invert so the internal level reads 1 = pressed.
  sw_debounce_chan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .raw_i    (~key_raw_i),
    .stable_o (key_stable),
    .accept_o (key_accept)
  );

  // Strobes are decided from the pre-update stable value, so they land on
  // the same edge the stable register flips.
  always_comb begin
    press_d   = key_accept & ~key_stable;
    release_d = key_accept &  key_stable;
    changed_d = |sw_accept;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      changed_q <= changed_d;
    end
  end

  assign sw_o          = sw_stable;
  assign key_pressed_o = key_stable;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign sw_changed_o  = changed_q;
endmodule

// File: tb/tb_sw_debounce.sv
// Directed checks of sw_debounce with a 4-cycle window and 2-stage sync.

module tb_sw_debounce;
  localparam int W = 10;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic         key_raw;
  logic [W-1:0] sw_o;
  logic         key_pressed, key_press, key_release, sw_changed;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int chg_cnt, press_cnt, rel_cnt;

  sw_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .sw_raw_i     (sw_raw),
    .key_raw_i    (key_raw),
    .sw_o         (sw_o),
    .key_pressed_o(key_pressed),
    .key_press_o  (key_press),
    .key_release_o(key_release),
    .sw_changed_o (sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sw_changed)  chg_cnt++;
      if (key_press)   press_cnt++;
      if (key_release) rel_cnt++;
    end
  endtask

  task automatic clr();
    chg_cnt   = 0;
    press_cnt = 0;
    rel_cnt   = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clr();
    reset_n = 1'b0;
    sw_raw  = 10'h3FF;
    key_raw = 1'b1;

    // Reset with switches already high
    tick(3);
    chk("rst_sw", 32'(sw_o), 32'h0);
    chk("rst_key", 32'(key_pressed), 32'h0);
    chk("rst_strobes", {29'h0, key_press, key_release, sw_changed}, 32'h0);
    reset_n = 1'b1;
    clr();
    tick(5);
    chk("post_rst_early_sw", 32'(sw_o), 32'h0);
    chk("post_rst_early_chg", 32'(chg_cnt), 32'h0);
    tick(1);
    chk("post_rst_sw", 32'(sw_o), 32'h3FF);
    chk("post_rst_chg", 32'(sw_changed), 32'h1);
    chk("post_rst_key", 32'(key_pressed), 32'h0);
    tick(1);
    chk("post_rst_chg_off", 32'(sw_changed), 32'h0);
    chk("post_rst_chg_cnt", 32'(chg_cnt), 32'h1);

    // Clean switch change 0 -> 005
    sw_raw = 10'h000;
    tick(8);
    chk("settle_zero", 32'(sw_o), 32'h0);
    clr();
    sw_raw = 10'h005;
    tick(5);
    chk("clean_early", 32'(sw_o), 32'h0);
    tick(1);
    chk("clean_sw", 32'(sw_o), 32'h005);
    chk("clean_chg", 32'(sw_changed), 32'h1);
    tick(3);
    chk("clean_chg_cnt", 32'(chg_cnt), 32'h1);

    // Bounce rejection on the key
    clr();
    key_raw = 1'b0; tick(3);
    key_raw = 1'b1; tick(2);
    key_raw = 1'b0; tick(2);
    key_raw = 1'b1; tick(10);
    chk("bounce_press_cnt", 32'(press_cnt), 32'h0);
    chk("bounce_level", 32'(key_pressed), 32'h0);

    // Press for 10 cycles, then release
    clr();
    key_raw = 1'b0;
    tick(5);
    chk("press_early", {30'h0, key_press, key_pressed}, 32'h0);
    tick(1);
    chk("press_pulse", 32'(key_press), 32'h1);
    chk("press_level", 32'(key_pressed), 32'h1);
    tick(1);
    chk("press_pulse_off", 32'(key_press), 32'h0);
    tick(3);
    key_raw = 1'b1;
    tick(5);
    chk("held_level", 32'(key_pressed), 32'h1);
    chk("release_early", 32'(key_release), 32'h0);
    tick(1);
    chk("release_pulse", 32'(key_release), 32'h1);
    chk("release_level", 32'(key_pressed), 32'h0);
    tick(1);
    chk("release_pulse_off", 32'(key_release), 32'h0);
    chk("pr_counts", {press_cnt[15:0], rel_cnt[15:0]}, 32'h0001_0001);

    // Simultaneous key press and switch bits 9,0
    sw_raw = 10'h000;
    tick(8);
    clr();
    key_raw = 1'b0;
    sw_raw  = 10'h201;
    tick(6);
    chk("sim_press", 32'(key_press), 32'h1);
    chk("sim_chg", 32'(sw_changed), 32'h1);
    chk("sim_sw", 32'(sw_o), 32'h201);
    tick(1);
    chk("sim_off", {30'h0, key_press, sw_changed}, 32'h0);
    chk("sim_counts", {press_cnt[15:0], chg_cnt[15:0]}, 32'h0001_0001);
    key_raw = 1'b1;
    sw_raw  = 10'h000;
    tick(10);

    // Reset mid-count
    clr();
    sw_raw = 10'h001;
    tick(4);
    reset_n = 1'b0;
    #1;
    chk("midrst_sw", 32'(sw_o), 32'h0);
    tick(3);
    chk("midrst_no_strobe", 32'(chg_cnt), 32'h0);
    chk("midrst_sw_hold", 32'(sw_o), 32'h0);
    reset_n = 1'b1;
    tick(5);
    chk("midrst_early", 32'(sw_o), 32'h0);
    tick(1);
    chk("midrst_sw_after", 32'(sw_o), 32'h001);
    chk("midrst_chg", 32'(sw_changed), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-conditioning stage that sits directly upstream of the processor core's switch port and single-step logic. It conditions the board's raw slide switches and push button. Each input is synchronized to `clk_i` and debounced with a per-input stability counter. The block presents a clean, glitch-free switch word to the core's `SW_i` input, plus one-cycle press/release/change strobes for the stepping and control logic.

## Interface

Parameters:
- `WIDTH`, 10: number of slide switches.
- `SYNC_STAGES`, 2: synchronizer flops per input; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a new level; legal range ≥ 1.

Ports:
- `clk_i`  in  1  system clock.
- `reset_n_i`  in  1  reset, asynchronous assert, active-low.
- `sw_raw_i`  in  WIDTH  raw slide switches, asynchronous, may bounce.
- `key_raw_i`  in  1  raw push button, active-low (idles high), asynchronous, may bounce.
- `sw_o`  out  WIDTH  debounced switch word; drives core `SW_i`.
- `key_pressed_o`  out  1  debounced button level, active-high (1 = held).
- `key_press_o`  out  1  one-cycle pulse on accepted press.
- `key_release_o`  out  1  one-cycle pulse on accepted release.
- `sw_changed_o`  out  1  one-cycle pulse when any `sw_o` bit updates.

## Operation

- There are WIDTH+1 independent channels: WIDTH switch channels plus 1 key channel.
  - The key channel uses the inverted `key_raw_i`, so pressed = 1 internally.
- Each channel has:
  - a SYNC_STAGES-deep synchronizer,
  - a stable register,
  - a counter of width clog2(DEBOUNCE_CYCLES), minimum 1 bit.
- Per channel, on each `clk_i` rising edge, with synced = last synchronizer stage:
  - If synced == stable: counter <= 0. Any glitch shorter than the window therefore restarts the count.
  - If synced != stable and counter == DEBOUNCE_CYCLES-1: stable <= synced and counter <= 0.
  - Otherwise: counter <= counter + 1.
- `sw_o` is the switch stable registers; `key_pressed_o` is the key stable register.
- Strobes are registered and asserted in the same cycle the stable value changes:
  - `key_press_o` on key stable 0→1.
  - `key_release_o` on key stable 1→0.
  - `sw_changed_o` when one or more switch channels update on that edge. Several bits updating on one edge produce a single pulse.
- Strobes are high for exactly one cycle per accepted transition and are never high in consecutive cycles for the same channel.
  - This holds because a new acceptance needs ≥ DEBOUNCE_CYCLES+... cycles.
  - Exception: when DEBOUNCE_CYCLES = 1, a channel may toggle every cycle if the input does.
- Reset values (asynchronous while `reset_n_i` = 0):
  - switch synchronizers 0, key synchronizers 0 (internal, i.e. raw high / released);
  - all counters 0;
  - `sw_o` = 0, `key_pressed_o` = 0;
  - all strobes 0.
- After reset release, switches already high are accepted through the normal debounce path. `sw_changed_o` pulses once for them.
- Reset asserted mid-count abandons the count with no strobe. Counting restarts from 0 after release.

## Timing

- Latency: a raw level change that holds steady from before edge N appears on the output and strobe after edge N + SYNC_STAGES + DEBOUNCE_CYCLES - 1.
  - This is SYNC_STAGES + DEBOUNCE_CYCLES edges counting edge N as the first sample.
- A bounce returning to the old level before acceptance produces no output change and no strobe. The counter is back at 0 one edge after the synced value matches.
- Simultaneous events on independent channels on the same edge are all honoured: both key and switch strobes may be high together.
- Pulse width ≥ DEBOUNCE_CYCLES+1 cycles is always accepted.
- Pulse width ≤ DEBOUNCE_CYCLES-1 cycles (at the synchronizer output) is always rejected.
- No combinational path exists from any input to any output.

## Test plan

All cases use DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2, WIDTH = 10.

- Reset: hold `reset_n_i` = 0 with `sw_raw_i` = 10'h3FF and `key_raw_i` = 1.
  - During reset: all outputs 0.
  - After release: `sw_o` = 10'h3FF and `sw_changed_o` = 1 for one cycle, exactly 6 edges after release; `key_pressed_o` stays 0.
- Clean switch change: `sw_raw_i` 0 → 10'h005 held.
  - `sw_o` = 10'h005 exactly 6 edges later, with a single `sw_changed_o` pulse.
- Bounce rejection: `key_raw_i` low 3 cycles, high 2, low 2, high.
  - No `key_press_o`; `key_pressed_o` stays 0.
- Press/release: `key_raw_i` low 10 cycles, then high.
  - `key_press_o` one-cycle pulse 6 edges after the fall.
  - `key_release_o` one-cycle pulse 6 edges after the rise.
  - `key_pressed_o` high between the two pulses.
- Simultaneous events: drive the key press and `sw_raw_i` bits 9 and 0 on the same edge.
  - `key_press_o` and a single `sw_changed_o` pulse on the same cycle; `sw_o` = 10'h201.
- Mid-count reset: change `sw_raw_i` to 10'h001, then assert `reset_n_i` = 0 after 4 edges.
  - No strobe; `sw_o` = 0 during reset.
  - After release: `sw_o` = 10'h001 6 edges later.
